rr_mux_arbiter_4: RTL and testbench

- Round-robin arbiter and sequencer for the shared 4:1 data mux.
- Four requesters compete for one output channel using valid/ready handshakes.
- The block generates the 2-bit mux select, gates each requester's ready, and registers the selected word into a single output stage.
- An optional burst quantum lets a winning requester keep the mux for several consecutive beats before rotation.

---
 rtl/rr_mux_arbiter_4.sv | 103 ++++++++++
 tb/tb_rr_mux_arbiter_4.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter for a shared 4:1 data mux with a registered output stage.
// A winner may keep the grant for up to QUANTUM consecutive beats before rotation.
module rr_mux_arbiter_4 #(
    parameter int WIDTH   = 4,
    parameter int QUANTUM = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       req_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [1:0]       owner, owner_nxt;
    logic [1:0]       last, last_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             load_en;
    logic             grant;
    logic             lock_hold;
    logic [1:0]       sel;
    logic [WIDTH-1:0] sel_data;

    // Search order is last+1, last+2, last+3, last; scanning downward lets the
    // nearest candidate overwrite the farther ones.
    function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] r;
        logic [1:0] i;
        r = p;
        for (int k = 4; k >= 1; k--) begin
            i = p + 2'(k);
            if (v[i]) r = i;
        end
        return r;
    endfunction

    always_comb begin
        load_en   = !out_valid || out_ready;
        grant     = |req_valid;
        lock_hold = (state == LOCKED) && req_valid[owner] && (cnt < 4'(QUANTUM));
        sel       = lock_hold ? owner : rr_pick(req_valid, last);
        req_ready = 4'b0000;
        if (!rst && load_en && grant) req_ready[sel] = 1'b1;
        case (sel)
            2'd0:    sel_data = d0;
            2'd1:    sel_data = d1;
            2'd2:    sel_data = d2;
            default: sel_data = d3;
        endcase
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        if (load_en) begin
            if (grant) begin
                state_nxt = LOCKED;
                owner_nxt = sel;
                last_nxt  = sel;
                // Expiry or rotation restarts the count even if the same requester wins again.
                cnt_nxt   = lock_hold ? cnt + 4'd1 : 4'd1;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 2'd0;
            last      <= 2'd3;
            cnt       <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
            if (load_en) begin
                out_valid <= grant;
                if (grant) begin
                    out_data <= sel_data;
                    out_src  <= sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed bench for rr_mux_arbiter_4: a QUANTUM=2 instance and a QUANTUM=1
// instance share the same stimulus.
module tb_rr_mux_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] d0, d1, d2, d3;
    logic       out_ready;

    logic [3:0] rdy2, rdy1;
    logic       ov2, ov1;
    logic [3:0] od2, od1;
    logic [1:0] os2, os1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter_4 #(.WIDTH(4), .QUANTUM(2)) dut_q2 (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .req_ready(rdy2), .out_valid(ov2), .out_data(od2), .out_src(os2),
        .out_ready(out_ready)
    );

    rr_mux_arbiter_4 #(.WIDTH(4), .QUANTUM(1)) dut_q1 (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .req_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_src(os1),
        .out_ready(out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; out_ready = 1'b1;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        step();
        checks++; if (ov2 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", ov2); end
        checks++; if (od2 !== 4'h0) begin fails++; $display("FAIL reset_out_data got %h want 0", od2); end
        checks++; if (os2 !== 2'd0) begin fails++; $display("FAIL reset_out_src got %0d want 0", os2); end
        checks++; if (rdy2 !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got %b want 0000", rdy2); end
        checks++; if (rdy1 !== 4'b0000) begin fails++; $display("FAIL reset_req_ready_q1 got %b want 0000", rdy1); end
        rst = 1'b0;
        #1;
        checks++; if (rdy2 !== 4'b0001) begin fails++; $display("FAIL reset_first_prio got %b want 0001", rdy2); end
    endtask

    task automatic test_round_robin();
        logic [1:0] src2;
        logic [1:0] src1;
        logic [3:0] rdy1_exp;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            src2 = 2'((i / 2) % 4);
            src1 = 2'(i % 4);
            rdy1_exp = 4'b0001 << ((i + 1) % 4);
            checks++; if (ov2 !== 1'b1 || os2 !== src2 || od2 !== 4'(src2) + 4'd1) begin
                fails++; $display("FAIL rr_q2 beat %0d got v=%b src=%0d data=%0d want v=1 src=%0d data=%0d", i, ov2, os2, od2, src2, src2 + 1);
            end
            checks++; if (ov1 !== 1'b1 || os1 !== src1 || od1 !== 4'(src1) + 4'd1) begin
                fails++; $display("FAIL rr_q1 beat %0d got v=%b src=%0d data=%0d want v=1 src=%0d data=%0d", i, ov1, os1, od1, src1, src1 + 1);
            end
            checks++; if (rdy1 !== rdy1_exp) begin
                fails++; $display("FAIL rr_q1_ready beat %0d got %b want %b", i, rdy1, rdy1_exp);
            end
        end
    endtask

    task automatic test_single_requester();
        req_valid = 4'b0100; d2 = 4'hA;
        do_reset();
        checks++; if (rdy2 !== 4'b0100 || ov2 !== 1'b0) begin
            fails++; $display("FAIL single_first got rdy=%b v=%b want rdy=0100 v=0", rdy2, ov2);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (ov2 !== 1'b1 || od2 !== 4'hA || os2 !== 2'd2 || rdy2 !== 4'b0100) begin
                fails++; $display("FAIL single beat %0d got v=%b data=%h src=%0d rdy=%b want v=1 data=a src=2 rdy=0100", i, ov2, od2, os2, rdy2);
            end
        end
    endtask

    task automatic test_backpressure();
        req_valid = 4'b1111; out_ready = 1'b1;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        do_reset();
        step();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rdy2 !== 4'b0000) begin
                fails++; $display("FAIL stall_ready cycle %0d got %b want 0000", i, rdy2);
            end
            step();
            checks++; if (ov2 !== 1'b1 || od2 !== 4'd1 || os2 !== 2'd0) begin
                fails++; $display("FAIL stall_hold cycle %0d got v=%b data=%0d src=%0d want v=1 data=1 src=0", i, ov2, od2, os2);
            end
        end
        out_ready = 1'b1;
        step();
        checks++; if (os2 !== 2'd0 || od2 !== 4'd1) begin
            fails++; $display("FAIL stall_resume1 got src=%0d data=%0d want src=0 data=1", os2, od2);
        end
        step();
        checks++; if (os2 !== 2'd1 || od2 !== 4'd2) begin
            fails++; $display("FAIL stall_resume2 got src=%0d data=%0d want src=1 data=2", os2, od2);
        end
    endtask

    task automatic test_drop_valid();
        req_valid = 4'b1111; out_ready = 1'b1;
        do_reset();
        step(); step(); step();
        checks++; if (os2 !== 2'd1) begin
            fails++; $display("FAIL drop_setup got src=%0d want 1", os2);
        end
        req_valid = 4'b1101;
        #1;
        checks++; if (rdy2 !== 4'b0100) begin
            fails++; $display("FAIL drop_ready got %b want 0100", rdy2);
        end
        step();
        checks++; if (os2 !== 2'd2 || od2 !== 4'd3) begin
            fails++; $display("FAIL drop_next got src=%0d data=%0d want src=2 data=3", os2, od2);
        end
        step();
        checks++; if (os2 !== 2'd2) begin
            fails++; $display("FAIL drop_second got src=%0d want 2", os2);
        end
        step();
        checks++; if (os2 !== 2'd3 || od2 !== 4'd4) begin
            fails++; $display("FAIL drop_third got src=%0d data=%0d want src=3 data=4", os2, od2);
        end
    endtask

    task automatic test_reset_mid_burst();
        req_valid = 4'b1111; out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) step();
        checks++; if (os2 !== 2'd3) begin
            fails++; $display("FAIL midrst_setup got src=%0d want 3", os2);
        end
        rst = 1'b1;
        #1;
        checks++; if (rdy2 !== 4'b0000) begin
            fails++; $display("FAIL midrst_ready_during got %b want 0000", rdy2);
        end
        step();
        checks++; if (ov2 !== 1'b0 || rdy2 !== 4'b0000) begin
            fails++; $display("FAIL midrst_after got v=%b rdy=%b want v=0 rdy=0000", ov2, rdy2);
        end
        rst = 1'b0;
        #1;
        checks++; if (rdy2 !== 4'b0001) begin
            fails++; $display("FAIL midrst_prio got %b want 0001", rdy2);
        end
        step();
        checks++; if (ov2 !== 1'b1 || os2 !== 2'd0 || od2 !== 4'd1) begin
            fails++; $display("FAIL midrst_first got v=%b src=%0d data=%0d want v=1 src=0 data=1", ov2, os2, od2);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 4'b0000; out_ready = 1'b1;
        d0 = 4'd0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0;
        test_reset();
        test_round_robin();
        test_single_requester();
        test_backpressure();
        test_drop_valid();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
